// File: rtl/shift_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits, one stop bit.
// The line is oversampled at CLKS_PER_BIT clocks per bit. The start bit is
// re-checked half a bit after its falling edge, and each later bit is sampled
// one full bit period after that, which lands near the middle of the bit.
// The bit order is captured at the start bit and held for the whole frame.
module shift_frame_rx #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sin,
    input  logic             dir,
    output logic [WIDTH-1:0] Q,
    output logic             q_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] shreg;
    logic             dir_lat;
    logic             bit_tick;

    assign bit_tick = (cnt == CNT_LAST);

    // State register; reset wins over every transition, including mid-frame.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: glitches shorter than half a bit fall back to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!sin) state_next = START;
            end
            START: begin
                if (cnt == CNT_HALF) state_next = sin ? IDLE : DATA;
            end
            DATA: begin
                if (bit_tick && (idx == IDX_LAST)) state_next = STOP;
            end
            STOP: begin
                if (bit_tick) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: anything outside IDLE counts as an active frame.
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: bit timing, shifting, and the registered result and pulses.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            dir_lat   <= 1'b0;
            Q         <= '0;
            q_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            q_valid   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!sin) dir_lat <= dir;
                end
                START: begin
                    idx <= '0;
                    if (cnt == CNT_HALF) cnt <= '0;
                    else                 cnt <= cnt + CW'(1);
                end
                DATA: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) idx <= '0;
                        else                 idx <= idx + IW'(1);
                        if (dir_lat) shreg <= {shreg[WIDTH-2:0], sin};
                        else         shreg <= {sin, shreg[WIDTH-1:1]};
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (sin) begin
                            Q       <= shreg;
                            q_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt <= '0;
                    idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_frame_rx.sv
// Directed bench for shift_frame_rx (WIDTH=4, CLKS_PER_BIT=4).
// Inputs change on the falling edge, so every bit is held across exactly
// CLKS_PER_BIT rising edges. Outputs are observed on the falling edge.
module tb_shift_frame_rx;

    localparam int WIDTH = 4;
    localparam int CPB   = 4;

    logic             clk = 1'b0;
    logic             clr;
    logic             sin;
    logic             dir;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             frame_err;
    logic             busy;

    int               checks   = 0;
    int               failures = 0;
    int               qv_count = 0;
    int               fe_count = 0;
    logic [WIDTH-1:0] q_log[$];

    shift_frame_rx #(
        .WIDTH(WIDTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .clr(clr),
        .sin(sin),
        .dir(dir),
        .Q(q),
        .q_valid(q_valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulse monitor: counts every cycle each pulse is high and logs Q on q_valid.
    always @(negedge clk) begin
        if (q_valid || frame_err) begin
            if (q_valid) begin
                qv_count++;
                q_log.push_back(q);
            end
            if (frame_err) fe_count++;
            check_output("pulse_exclusive", 32'(q_valid & frame_err), 32'd0);
        end
    end

    task automatic clear_pulses();
        qv_count = 0;
        fe_count = 0;
        q_log.delete();
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        sin = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // seq[0] goes on the line first; dir may be changed after the start bit.
    task automatic apply_stimulus(input logic [WIDTH-1:0] seq, input logic stop_bit,
                                  input logic dir_start, input logic dir_mid);
        dir = dir_start;
        send_bit(1'b0);
        dir = dir_mid;
        for (int i = 0; i < WIDTH; i++) send_bit(seq[i]);
        send_bit(stop_bit);
        sin = 1'b1;
    endtask

    initial begin
        clr = 1'b1;
        sin = 1'b1;
        dir = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_q", 32'(q), 32'h0);
        check_output("reset_q_valid", 32'(q_valid), 32'h0);
        check_output("reset_frame_err", 32'(frame_err), 32'h0);
        check_output("reset_busy", 32'(busy), 32'h0);
        clr = 1'b0;
        @(negedge clk);

        // MSB-first frame, line bits 1,1,0,1.
        clear_pulses();
        apply_stimulus(4'b1011, 1'b1, 1'b1, 1'b1);
        idle_cycles(4);
        check_output("msb_first_q", 32'(q), 32'hD);
        check_output("msb_first_qv_count", 32'(qv_count), 32'd1);
        check_output("msb_first_fe_count", 32'(fe_count), 32'd0);
        check_output("msb_first_busy", 32'(busy), 32'h0);

        // LSB-first frame, dir flipped mid-frame must be ignored.
        clear_pulses();
        apply_stimulus(4'b1011, 1'b1, 1'b0, 1'b1);
        dir = 1'b0;
        idle_cycles(4);
        check_output("lsb_first_q", 32'(q), 32'hB);
        check_output("lsb_first_qv_count", 32'(qv_count), 32'd1);
        check_output("lsb_first_fe_count", 32'(fe_count), 32'd0);

        // One-cycle low glitch on the line.
        clear_pulses();
        sin = 1'b0;
        @(negedge clk);
        check_output("glitch_busy_high", 32'(busy), 32'h1);
        idle_cycles(8);
        check_output("glitch_busy_low", 32'(busy), 32'h0);
        check_output("glitch_qv_count", 32'(qv_count), 32'd0);
        check_output("glitch_fe_count", 32'(fe_count), 32'd0);
        check_output("glitch_q_hold", 32'(q), 32'hB);

        // All-zero frame with a bad stop bit.
        clear_pulses();
        apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        idle_cycles(10);
        check_output("frame_err_count", 32'(fe_count), 32'd1);
        check_output("frame_err_qv_count", 32'(qv_count), 32'd0);
        check_output("frame_err_q_hold", 32'(q), 32'hB);
        check_output("frame_err_busy", 32'(busy), 32'h0);

        // Back-to-back frames 1011 then 0110, LSB first.
        clear_pulses();
        apply_stimulus(4'b1011, 1'b1, 1'b0, 1'b0);
        apply_stimulus(4'b0110, 1'b1, 1'b0, 1'b0);
        idle_cycles(4);
        check_output("b2b_qv_count", 32'(qv_count), 32'd2);
        check_output("b2b_first_q", 32'((q_log.size() > 0) ? q_log[0] : 4'hx), 32'hB);
        check_output("b2b_second_q", 32'((q_log.size() > 1) ? q_log[1] : 4'hx), 32'h6);
        check_output("b2b_fe_count", 32'(fe_count), 32'd0);

        // Reset while receiving data bit index 2.
        clear_pulses();
        dir = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check_output("abort_busy_before", 32'(busy), 32'h1);
        clr = 1'b1;
        @(negedge clk);
        check_output("abort_busy", 32'(busy), 32'h0);
        check_output("abort_q", 32'(q), 32'h0);
        clr = 1'b0;
        idle_cycles(12);
        check_output("abort_qv_count", 32'(qv_count), 32'd0);
        check_output("abort_fe_count", 32'(fe_count), 32'd0);

        // Clean frame after the abort.
        apply_stimulus(4'b0011, 1'b1, 1'b0, 1'b0);
        idle_cycles(4);
        check_output("post_abort_q", 32'(q), 32'h3);
        check_output("post_abort_qv_count", 32'(qv_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_frame_rx.md
SHIFT_FRAME_RX -- requirements
Module: shift_frame_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning number of data bits per frame (>=2).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit (even, >=2).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port sin, input, 1, meaning serial line; idle level 1.
REQ-006 SHALL have port dir, input, 1, meaning bit order: 0 = LSB first (shift right), 1 = MSB first (shift left).
REQ-007 SHALL have port Q, output, WIDTH, meaning last correctly framed parallel word.
REQ-008 SHALL have port q_valid, output, 1, meaning one-cycle pulse: Q just updated.
REQ-009 SHALL have port frame_err, output, 1, meaning one-cycle pulse: stop bit sampled as 0.
REQ-010 SHALL have port busy, output, 1, meaning high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA and STOP, with bit-period counter cnt and bit index idx.
REQ-012 IDLE: when sin==0 is sampled, SHALL go to START with cnt=0 and latch dir for the whole frame; otherwise SHALL stay in IDLE.
REQ-013 START: SHALL increment cnt each cycle; at cnt==CLKS_PER_BIT/2-1, sin==0 SHALL go to DATA (cnt=0, idx=0), and sin==1 SHALL return to IDLE silently as a glitch.
REQ-014 DATA: at cnt==CLKS_PER_BIT-1 SHALL sample sin into the shift register, reset cnt to 0 and increment idx; after sample WIDTH it SHALL go to STOP.
REQ-015 Shift rule: latched dir=0 SHALL shift the register right with sin entering the MSB; latched dir=1 SHALL shift it left with sin entering the LSB.
REQ-016 Result: after WIDTH samples, the first bit received SHALL end in bit 0 for dir=0 and in bit WIDTH-1 for dir=1.
REQ-017 STOP: at cnt==CLKS_PER_BIT-1 the block SHALL sample sin and return to IDLE on the following edge.
REQ-018 Stop sample 1: SHALL load Q from the shift register and pulse q_valid high for exactly one cycle, the cycle after the stop sample.
REQ-019 Stop sample 0: SHALL pulse frame_err for one cycle in that same cycle, and Q SHALL hold its previous value.
REQ-020 q_valid and frame_err SHALL never be high together.
REQ-021 A new start bit SHALL be accepted in the first IDLE cycle after STOP, so back-to-back frames are not lost.
REQ-022 Changes on dir mid-frame SHALL be ignored; sin is treated as already synchronous to clk.

Reset
REQ-023 clr high at a rising edge SHALL force IDLE, cnt=0, idx=0, shift register=0, Q=0, q_valid=0, frame_err=0 and busy=0.
REQ-024 clr SHALL take priority over every FSM transition, including mid-frame; no q_valid or frame_err pulse SHALL follow an aborted frame.
REQ-025 From the first edge with clr low, the block SHALL be ready to detect a start bit.

Verification (WIDTH=4, CLKS_PER_BIT=4)
REQ-026 dir=0, line sequence start 0, data 1,1,0,1, stop 1 (4 clk each) -> Q=4'b1011, q_valid one cycle, frame_err=0.
REQ-027 dir=1, same line sequence -> Q=4'b1101, one q_valid pulse.
REQ-028 sin low for 1 cycle then high -> return to IDLE, no q_valid, no frame_err, Q unchanged.
REQ-029 Frame with data 0,0,0,0 and stop bit 0 after a prior Q=4'b1011 -> frame_err one cycle, Q stays 4'b1011, q_valid=0.
REQ-030 clr pulsed during DATA idx=2 -> busy=0 and Q=0 on the next edge, no pulses, then the next full frame is received correctly.
REQ-031 Two frames 1011 then 0110 (dir=0), second start bit immediately after first stop -> two q_valid pulses, Q=4'b1011 then 4'b0110.
